// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer: next-state select and condition
// select encodings, the fetch state and the opcode/funct dispatch table.
package microseq_pkg;

    localparam int unsigned STATE_W_DEF = 7;
    localparam int unsigned ST_FETCH    = 0;

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_FETCH    = 3'b001,
        NS_JUMP     = 3'b010,
        NS_INC      = 3'b011,
        NS_CBRANCH  = 3'b100,
        NS_WAIT     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RETURN   = 3'b111
    } ns_sel_e;

    typedef enum logic [1:0] {
        COND_MOC   = 2'b00,
        COND_BR    = 2'b01,
        COND_ONE   = 2'b10,
        COND_OVF   = 2'b11
    } cond_sel_e;

    // Instruction fields
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    // Microcode entry states for each instruction
    localparam int unsigned ENC_ADDU  = 6;
    localparam int unsigned ENC_LW    = 7;
    localparam int unsigned ENC_SW    = 11;
    localparam int unsigned ENC_BEQ   = 12;
    localparam int unsigned ENC_SUBU  = 16;
    localparam int unsigned ENC_AND   = 17;
    localparam int unsigned ENC_OR    = 18;
    localparam int unsigned ENC_SLT   = 19;
    localparam int unsigned ENC_ADDIU = 20;
    localparam int unsigned ENC_ANDI  = 21;
    localparam int unsigned ENC_ORI   = 22;
    localparam int unsigned ENC_LUI   = 23;
    localparam int unsigned ENC_SLTI  = 24;

endpackage

// File: rtl/microseq_next_state_encoder.sv
// Combinational dispatch encoder: maps IR opcode/funct to the microcode entry
// state; unrecognised instructions map to the fetch state.
module opcode_encoder
    import microseq_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEF
) (
    input  logic [5:0]         ir_opcode,
    input  logic [5:0]         ir_funct,
    output logic [STATE_W-1:0] enc_state
);

    // Table lookup; R-type decodes on funct, everything else on opcode
    always_comb begin
        enc_state = STATE_W'(ST_FETCH);
        if (ir_opcode == OP_RTYPE) begin
            case (ir_funct)
                FN_ADDU: enc_state = STATE_W'(ENC_ADDU);
                FN_SUBU: enc_state = STATE_W'(ENC_SUBU);
                FN_AND:  enc_state = STATE_W'(ENC_AND);
                FN_OR:   enc_state = STATE_W'(ENC_OR);
                FN_SLT:  enc_state = STATE_W'(ENC_SLT);
                default: enc_state = STATE_W'(ST_FETCH);
            endcase
        end else begin
            case (ir_opcode)
                OP_ADDIU: enc_state = STATE_W'(ENC_ADDIU);
                OP_ANDI:  enc_state = STATE_W'(ENC_ANDI);
                OP_ORI:   enc_state = STATE_W'(ENC_ORI);
                OP_LUI:   enc_state = STATE_W'(ENC_LUI);
                OP_SLTI:  enc_state = STATE_W'(ENC_SLTI);
                OP_LW:    enc_state = STATE_W'(ENC_LW);
                OP_SW:    enc_state = STATE_W'(ENC_SW);
                OP_BEQ:   enc_state = STATE_W'(ENC_BEQ);
                default:  enc_state = STATE_W'(ST_FETCH);
            endcase
        end
    end

endmodule

// File: rtl/microseq_next_state.sv
// Microsequencer: state register, next-state mux, wait-loop timeout counter.
// Build option: define USTACK_EN for a one-entry micro-subroutine return
// register (call/return); otherwise call and return both go to fetch.
module microseq_next_state
    import microseq_pkg::*;
#(
    parameter int unsigned STATE_W  = STATE_W_DEF,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_sel,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [5:0]         ir_opcode,
    input  logic [5:0]         ir_funct,
    input  logic               moc,
    input  logic               br_cond,
    input  logic               ovf,
    output logic [STATE_W-1:0] state,
    output logic               mem_timeout
);

    // Counter only needs to reach WAIT_MAX-1
    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    ns_sel_e             ns;
    cond_sel_e           cs;
    logic                cond;
    logic [STATE_W-1:0]  inc;
    logic [STATE_W-1:0]  enc_state;
    logic [STATE_W-1:0]  state_nx;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_cnt_nx;
    logic                timeout_nx;

    assign ns  = ns_sel_e'(ns_sel);
    assign cs  = cond_sel_e'(cond_sel);
    assign inc = state + STATE_W'(1);

    opcode_encoder #(
        .STATE_W (STATE_W)
    ) u_enc (
        .ir_opcode (ir_opcode),
        .ir_funct  (ir_funct),
        .enc_state (enc_state)
    );

    // Condition select with optional inversion
    always_comb begin
        cond = 1'b0;
        case (cs)
            COND_MOC: cond = moc;
            COND_BR:  cond = br_cond;
            COND_ONE: cond = 1'b1;
            COND_OVF: cond = ovf;
            default:  cond = 1'b0;
        endcase
        cond = cond ^ cond_inv;
    end

`ifdef USTACK_EN
    logic [STATE_W-1:0] ret_reg, ret_reg_nx;
    logic               ret_vld, ret_vld_nx;
`endif

    // Next-state decode; wait counter clears on every cycle that is not a hold
    always_comb begin
        state_nx    = STATE_W'(ST_FETCH);
        wait_cnt_nx = '0;
        timeout_nx  = 1'b0;
`ifdef USTACK_EN
        ret_reg_nx  = ret_reg;
        ret_vld_nx  = ret_vld;
`endif
        case (ns)
            NS_DISPATCH: state_nx = enc_state;
            NS_FETCH:    state_nx = STATE_W'(ST_FETCH);
            NS_JUMP:     state_nx = cr_addr;
            NS_INC:      state_nx = inc;
            NS_CBRANCH:  state_nx = cond ? cr_addr : inc;
            NS_WAIT: begin
                if (cond) begin
                    state_nx = inc;
                end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    state_nx   = STATE_W'(ST_FETCH);
                    timeout_nx = 1'b1;
                end else begin
                    state_nx    = state;
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
`ifdef USTACK_EN
            NS_CALL: begin
                ret_reg_nx = inc;
                ret_vld_nx = 1'b1;
                state_nx   = cr_addr;
            end
            NS_RETURN: begin
                state_nx   = ret_vld ? ret_reg : STATE_W'(ST_FETCH);
                ret_vld_nx = 1'b0;
            end
`else
            NS_CALL:     state_nx = STATE_W'(ST_FETCH);
            NS_RETURN:   state_nx = STATE_W'(ST_FETCH);
`endif
            default:     state_nx = STATE_W'(ST_FETCH);
        endcase
    end

    // State, counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_timeout <= timeout_nx;
        end
    end

`ifdef USTACK_EN
    // Return register
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_reg <= '0;
            ret_vld <= 1'b0;
        end else begin
            ret_reg <= ret_reg_nx;
            ret_vld <= ret_vld_nx;
        end
    end
`endif

endmodule

// File: tb/tb_microseq_next_state.sv
// Self-checking bench for microseq_next_state (WAIT_MAX overridden to 4).
// Honours USTACK_EN the same way as the design.
module tb_microseq_next_state;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ns_sel;
    logic [1:0] cond_sel;
    logic       cond_inv;
    logic [6:0] cr_addr;
    logic [5:0] ir_opcode;
    logic [5:0] ir_funct;
    logic       moc;
    logic       br_cond;
    logic       ovf;
    logic [6:0] state;
    logic       mem_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string      nm;
        logic       rst;
        logic [2:0] ns;
        logic [6:0] addr;
        logic [1:0] cs;
        logic       inv;
        logic       m;
        logic       b;
        logic       o;
        logic [5:0] op;
        logic [5:0] fn;
        logic [6:0] es;
        logic       eto;
    } row_t;

    typedef struct {
        string      nm;
        logic [6:0] st;
        logic       to;
    } exp_t;

    exp_t sb[$];

    microseq_next_state #(
        .STATE_W  (7),
        .WAIT_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ns_sel      (ns_sel),
        .cond_sel    (cond_sel),
        .cond_inv    (cond_inv),
        .cr_addr     (cr_addr),
        .ir_opcode   (ir_opcode),
        .ir_funct    (ir_funct),
        .moc         (moc),
        .br_cond     (br_cond),
        .ovf         (ovf),
        .state       (state),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input string nm, input logic rst, input logic [2:0] ns,
                                input logic [6:0] addr, input logic [1:0] cs, input logic inv,
                                input logic m, input logic b, input logic o,
                                input logic [5:0] op, input logic [5:0] fn,
                                input logic [6:0] es, input logic eto);
        row_t r;
        r.nm = nm; r.rst = rst; r.ns = ns; r.addr = addr; r.cs = cs; r.inv = inv;
        r.m = m; r.b = b; r.o = o; r.op = op; r.fn = fn; r.es = es; r.eto = eto;
        return r;
    endfunction

    // Apply one cycle of stimulus, queue its expected result, advance past the edge
    task automatic drive(input row_t r);
        exp_t e;
        reset = r.rst; ns_sel = r.ns; cr_addr = r.addr; cond_sel = r.cs; cond_inv = r.inv;
        moc = r.m; br_cond = r.b; ovf = r.o; ir_opcode = r.op; ir_funct = r.fn;
        e.nm = r.nm; e.st = r.es; e.to = r.eto;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("rst_init",   1, 3'b010, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("rst_to45",   0, 3'b010, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd45, 0));
        rows.push_back(mk("rst_hold1",  1, 3'b010, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("rst_hold2",  1, 3'b011, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("rst_resume1",0, 3'b011, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd1,  0));
        rows.push_back(mk("rst_resume2",0, 3'b011, 7'd45, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd2,  0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    task automatic test_increment;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("inc_fetch", 0, 3'b001, 7'd9,   2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,   0));
        rows.push_back(mk("inc_1",     0, 3'b011, 7'd9,   2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd1,   0));
        rows.push_back(mk("inc_2",     0, 3'b011, 7'd9,   2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd2,   0));
        rows.push_back(mk("inc_3",     0, 3'b011, 7'd9,   2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd3,   0));
        rows.push_back(mk("inc_j127",  0, 3'b010, 7'd127, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd127, 0));
        rows.push_back(mk("inc_wrap",  0, 3'b011, 7'd127, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,   0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    task automatic test_dispatch;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("disp_lw",    0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h23, 6'h00, 7'd7,  0));
        rows.push_back(mk("disp_addu",  0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h21, 7'd6,  0));
        rows.push_back(mk("disp_bad",   0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h3F, 6'h21, 7'd0,  0));
        rows.push_back(mk("disp_sw",    0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h2B, 6'h00, 7'd11, 0));
        rows.push_back(mk("disp_slt",   0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h2A, 7'd19, 0));
        rows.push_back(mk("disp_badfn", 0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h22, 7'd0,  0));
        rows.push_back(mk("disp_lui",   0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h0F, 6'h00, 7'd23, 0));
        rows.push_back(mk("disp_beq",   0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h04, 6'h00, 7'd12, 0));
        rows.push_back(mk("disp_subu",  0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h23, 7'd16, 0));
        rows.push_back(mk("disp_slti",  0, 3'b000, 7'd0, 2'b00, 0, 0, 0, 0, 6'h0A, 6'h00, 7'd24, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    task automatic test_cond_branch;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("br_j3",      0, 3'b010, 7'd3,  2'b01, 0, 0, 0, 0, 6'h00, 6'h00, 7'd3,  0));
        rows.push_back(mk("br_taken",   0, 3'b100, 7'd10, 2'b01, 0, 0, 1, 0, 6'h00, 6'h00, 7'd10, 0));
        rows.push_back(mk("br_nottaken",0, 3'b100, 7'd10, 2'b01, 0, 0, 0, 0, 6'h00, 6'h00, 7'd11, 0));
        rows.push_back(mk("br_inv",     0, 3'b100, 7'd10, 2'b01, 1, 0, 1, 0, 6'h00, 6'h00, 7'd12, 0));
        rows.push_back(mk("br_const1i", 0, 3'b100, 7'd10, 2'b10, 1, 0, 1, 0, 6'h00, 6'h00, 7'd13, 0));
        rows.push_back(mk("br_ovf",     0, 3'b100, 7'd10, 2'b11, 0, 0, 0, 1, 6'h00, 6'h00, 7'd10, 0));
        rows.push_back(mk("br_moc0",    0, 3'b100, 7'd50, 2'b00, 0, 0, 1, 1, 6'h00, 6'h00, 7'd11, 0));
        rows.push_back(mk("br_const1",  0, 3'b100, 7'd50, 2'b10, 0, 0, 0, 0, 6'h00, 6'h00, 7'd50, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    task automatic test_wait_loop;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("wt_j8",     0, 3'b010, 7'd8, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt_hold1",  0, 3'b101, 7'd0, 2'b00, 0, 0, 1, 1, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt_hold2",  0, 3'b101, 7'd0, 2'b00, 0, 0, 1, 1, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt_hold3",  0, 3'b101, 7'd0, 2'b00, 0, 0, 1, 1, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt_tmo",    0, 3'b101, 7'd0, 2'b00, 0, 0, 1, 1, 6'h00, 6'h00, 7'd0, 1));
        rows.push_back(mk("wt_pulse1", 0, 3'b011, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd1, 0));
        rows.push_back(mk("wt2_j8",    0, 3'b010, 7'd8, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt2_hold1", 0, 3'b101, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt2_hold2", 0, 3'b101, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt2_moc",   0, 3'b101, 7'd0, 2'b00, 0, 1, 0, 0, 6'h00, 6'h00, 7'd9, 0));
        rows.push_back(mk("wt3_j8",    0, 3'b010, 7'd8, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt3_hold1", 0, 3'b101, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt3_hold2", 0, 3'b101, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt3_hold3", 0, 3'b101, 7'd0, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt3_prio",  0, 3'b101, 7'd0, 2'b00, 0, 1, 0, 0, 6'h00, 6'h00, 7'd9, 0));
        rows.push_back(mk("wt4_j8",    0, 3'b010, 7'd8, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt4_inv1",  0, 3'b101, 7'd0, 2'b00, 1, 1, 0, 0, 6'h00, 6'h00, 7'd8, 0));
        rows.push_back(mk("wt4_inv2",  0, 3'b101, 7'd0, 2'b00, 1, 0, 0, 0, 6'h00, 6'h00, 7'd9, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    task automatic test_call_return;
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("cr_j5",     0, 3'b010, 7'd5,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd5,  0));
`ifdef USTACK_EN
        rows.push_back(mk("cr_call",   0, 3'b110, 7'd40, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd40, 0));
        rows.push_back(mk("cr_ret",    0, 3'b111, 7'd0,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd6,  0));
        rows.push_back(mk("cr_ret2",   0, 3'b111, 7'd0,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("cr_j5b",    0, 3'b010, 7'd5,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd5,  0));
        rows.push_back(mk("cr_call1",  0, 3'b110, 7'd40, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd40, 0));
        rows.push_back(mk("cr_callov", 0, 3'b110, 7'd50, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd50, 0));
        rows.push_back(mk("cr_retov",  0, 3'b111, 7'd0,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd41, 0));
        rows.push_back(mk("cr_call3",  0, 3'b110, 7'd60, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd60, 0));
        rows.push_back(mk("cr_rst",    1, 3'b111, 7'd0,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("cr_retrst", 0, 3'b111, 7'd0,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
`else
        rows.push_back(mk("cr_call",   0, 3'b110, 7'd40, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
        rows.push_back(mk("cr_j5b",    0, 3'b010, 7'd5,  2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd5,  0));
        rows.push_back(mk("cr_ret",    0, 3'b111, 7'd40, 2'b00, 0, 0, 0, 0, 6'h00, 6'h00, 7'd0,  0));
`endif
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            n_cmp++;
            if (state !== e.st || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s: state=%0d mem_timeout=%b, expected state=%0d mem_timeout=%b",
                         e.nm, state, mem_timeout, e.st, e.to);
            end
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ns_sel = 3'b001; cond_sel = 2'b00; cond_inv = 1'b0; cr_addr = '0;
        ir_opcode = '0; ir_funct = '0; moc = 1'b0; br_cond = 1'b0; ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_increment();
        test_dispatch();
        test_cond_branch();
        test_wait_loop();
        test_call_return();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
